rv32is: RTL and testbench

- Single-cycle RV32I integer core with separate instruction and data memory ports.
- Sits inside the CPU test shell.
- Instruction memory is a synchronous-read ROM; data memory is a byte-maskable RAM that performs sign/zero extension and lane selection itself.
- Exposes debug outputs (retired PC, retire strobe, halt) for trace comparison.

---
 rtl/rv32is_pkg.sv | 49 ++++
 rtl/rv32is_regfile.sv | 44 ++++
 rtl/rv32is.sv | 180 ++++++++++++++++++
 tb/tb_rv32is.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32is_pkg.sv
// Shared encodings for the rv32is single-cycle RV32I core: opcodes, ALU operations,
// branch conditions and data-memory op codes, plus the ALU-operation decoder.
package rv32is_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  // alt is instruction bit 30; it selects SUB only for register-register ops.
  function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt,
                                         input logic is_reg);
    alu_decode = ALU_ADD;
    case (funct3)
      3'b000:  alu_decode = (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_decode = ALU_SLL;
      3'b010:  alu_decode = ALU_SLT;
      3'b011:  alu_decode = ALU_SLTU;
      3'b100:  alu_decode = ALU_XOR;
      3'b101:  alu_decode = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_decode = ALU_OR;
      default: alu_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32is_regfile.sv
// 32 x 32-bit integer register file: two async read ports, one write port, x0 reads zero.
// RV32IS_DBG_REGS_EN adds a flat combinational tap of every register.
module rv32is_regfile
  import rv32is_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic [4:0]     i_raddr1,
  input  logic [4:0]     i_raddr2,
  output logic [31:0]    o_rdata1,
  output logic [31:0]    o_rdata2,
  input  logic           i_we,
  input  logic [4:0]     i_waddr,
  input  logic [31:0]    i_wdata
`ifdef RV32IS_DBG_REGS_EN
  ,
  output logic [1023:0]  o_dbgregs
`endif
);

  logic [31:0] r_regs [0:31];

  // NOTE: this array is reset because the core's architectural state must read zero after
  // reset; the reset branch clears every entry and the write port never touches entry 0.
  // NOTE: state updates use <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

`ifdef RV32IS_DBG_REGS_EN
  assign o_dbgregs[31:0] = 32'd0;
  for (genvar g = 1; g < 32; g++) begin : g_dbg
    assign o_dbgregs[32*g +: 32] = r_regs[g];
  end
`endif

endmodule

// File: rtl/rv32is.sv
// rv32is: single-cycle RV32I core with synchronous-read instruction ROM and extending data RAM.
// Define RV32IS_DBG_REGS_EN to expose the whole register file on dbgregs.
module rv32is
  import rv32is_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  output logic [31:0]    imemaddr,
  input  logic [31:0]    imemdataout,
  output logic           imemclk,
  output logic [31:0]    dmemaddr,
  input  logic [31:0]    dmemdataout,
  output logic [31:0]    dmemdatain,
  output logic           dmemrdclk,
  output logic           dmemwrclk,
  output logic [2:0]     dmemop,
  output logic           dmemwe,
  output logic [31:0]    dbg_pc,
  output logic           done,
  output logic           wb
`ifdef RV32IS_DBG_REGS_EN
  ,
  output logic [1023:0]  dbgregs
`endif
);

  logic [31:0] r_pc;
  logic        r_halted;

  logic [31:0] w_instr;
  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_data, w_rs2_data, w_pc_plus4, w_addr_sum;
  logic [31:0] w_alu_b, w_alu_y, w_rd_data, w_next_pc;
  alu_op_e     w_alu_op;
  logic        w_zero, w_halt, w_rd_we, w_store, w_br_taken;
  logic        w_load_ok, w_store_ok, w_shift_ok, w_op_ok;

  assign w_instr  = imemdataout;
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];
  assign w_funct7 = w_instr[31:25];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'd0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};

  // An all-zero word halts the core until the next reset.
  assign w_zero = (w_instr == 32'd0);
  assign w_halt = r_halted | w_zero;

  rv32is_regfile u_regfile (
    .clock     (clock),
    .reset     (reset),
    .i_raddr1  (w_rs1),
    .i_raddr2  (w_rs2),
    .o_rdata1  (w_rs1_data),
    .o_rdata2  (w_rs2_data),
    .i_we      (w_rd_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_rd_data)
`ifdef RV32IS_DBG_REGS_EN
    ,
    .o_dbgregs (dbgregs)
`endif
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_addr_sum = w_rs1_data + w_imm_i;

  assign w_load_ok  = (w_funct3 == MEM_B) || (w_funct3 == MEM_H) || (w_funct3 == MEM_W) ||
                      (w_funct3 == MEM_BU) || (w_funct3 == MEM_HU);
  assign w_store_ok = (w_funct3 == MEM_B) || (w_funct3 == MEM_H) || (w_funct3 == MEM_W);
  assign w_shift_ok = (w_funct3 == 3'b001) ? (w_funct7 == 7'h00) :
                      (w_funct3 == 3'b101) ? ((w_funct7 == 7'h00) || (w_funct7 == 7'h20)) :
                      1'b1;
  assign w_op_ok    = (w_funct7 == 7'h00) ||
                      ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));

  assign w_alu_b  = (w_opcode == OPC_OP) ? w_rs2_data : w_imm_i;
  assign w_alu_op = alu_decode(w_funct3, w_funct7[5], w_opcode == OPC_OP);

  always_comb begin
    w_alu_y = 32'd0;
    case (w_alu_op)
      ALU_ADD:  w_alu_y = w_rs1_data + w_alu_b;
      ALU_SUB:  w_alu_y = w_rs1_data - w_alu_b;
      ALU_SLL:  w_alu_y = w_rs1_data << w_alu_b[4:0];
      ALU_SLT:  w_alu_y = {31'd0, $signed(w_rs1_data) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_y = {31'd0, w_rs1_data < w_alu_b};
      ALU_XOR:  w_alu_y = w_rs1_data ^ w_alu_b;
      ALU_SRL:  w_alu_y = w_rs1_data >> w_alu_b[4:0];
      ALU_SRA:  w_alu_y = $signed(w_rs1_data) >>> w_alu_b[4:0];
      ALU_OR:   w_alu_y = w_rs1_data | w_alu_b;
      ALU_AND:  w_alu_y = w_rs1_data & w_alu_b;
      default:  w_alu_y = 32'd0;
    endcase
  end

  always_comb begin
    w_br_taken = 1'b0;
    case (w_funct3)
      BR_BEQ:  w_br_taken = (w_rs1_data == w_rs2_data);
      BR_BNE:  w_br_taken = (w_rs1_data != w_rs2_data);
      BR_BLT:  w_br_taken = ($signed(w_rs1_data) < $signed(w_rs2_data));
      BR_BGE:  w_br_taken = ($signed(w_rs1_data) >= $signed(w_rs2_data));
      BR_BLTU: w_br_taken = (w_rs1_data < w_rs2_data);
      BR_BGEU: w_br_taken = (w_rs1_data >= w_rs2_data);
      default: w_br_taken = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every signal driven here is defaulted first, so no path can infer a latch.
    w_next_pc = w_pc_plus4;
    w_rd_we   = 1'b0;
    w_rd_data = w_alu_y;
    w_store   = 1'b0;
    case (w_opcode)
      OPC_LUI:    begin w_rd_we = 1'b1; w_rd_data = w_imm_u; end
      OPC_AUIPC:  begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
      OPC_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OPC_JALR: if (w_funct3 == 3'b000) begin
        w_rd_we   = 1'b1;
        w_rd_data = w_pc_plus4;
        w_next_pc = w_addr_sum & ~32'd1;
      end
      OPC_BRANCH: if (w_br_taken) w_next_pc = r_pc + w_imm_b;
      OPC_LOAD:   if (w_load_ok) begin w_rd_we = 1'b1; w_rd_data = dmemdataout; end
      OPC_STORE:  w_store = w_store_ok;
      OPC_OP_IMM: w_rd_we = w_shift_ok;
      OPC_OP:     w_rd_we = w_op_ok;
      default:    ;
    endcase
    if (w_halt) begin
      w_next_pc = r_pc;
      w_rd_we   = 1'b0;
      w_store   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_halted <= 1'b0;
    end else begin
      r_pc <= w_next_pc;
      if (w_zero) r_halted <= 1'b1;
    end
  end

  // The ROM registers imemaddr on the same edge that loads r_pc, so it must see next_pc.
  assign imemaddr   = reset ? w_next_pc : RESET_PC;
  assign imemclk    = clock;
  assign dmemrdclk  = ~clock;
  assign dmemwrclk  = clock;
  assign dmemaddr   = w_rs1_data + ((w_opcode == OPC_STORE) ? w_imm_s : w_imm_i);
  assign dmemdatain = w_rs2_data;
  assign dmemop     = w_funct3;
  assign dmemwe     = reset & w_store;
  assign dbg_pc     = r_pc;
  assign done       = reset & w_halt;
  assign wb         = reset & ~w_halt;

endmodule

// File: tb/tb_rv32is.sv
// Directed bench for rv32is: programs are loaded into a ROM model, expected retirements are
// queued up front and compared against wb/dbg_pc/store outputs as the core runs.
module tb_rv32is;
  import rv32is_pkg::*;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [31:0]    imemaddr, imemdataout, dmemaddr, dmemdataout, dmemdatain, dbg_pc;
  logic           imemclk, dmemrdclk, dmemwrclk, dmemwe, done, wb;
  logic [2:0]     dmemop;
`ifdef RV32IS_DBG_REGS_EN
  logic [1023:0]  dbgregs;
`endif

  logic [31:0] rom  [0:63];
  logic [31:0] dmem [0:255];

  typedef struct {
    logic [31:0] pc;
    logic        st;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;

  rv32is #(.RESET_PC(32'h0)) dut (
    .clock       (clock),
    .reset       (reset),
    .imemaddr    (imemaddr),
    .imemdataout (imemdataout),
    .imemclk     (imemclk),
    .dmemaddr    (dmemaddr),
    .dmemdataout (dmemdataout),
    .dmemdatain  (dmemdatain),
    .dmemrdclk   (dmemrdclk),
    .dmemwrclk   (dmemwrclk),
    .dmemop      (dmemop),
    .dmemwe      (dmemwe),
    .dbg_pc      (dbg_pc),
    .done        (done),
    .wb          (wb)
`ifdef RV32IS_DBG_REGS_EN
    ,
    .dbgregs     (dbgregs)
`endif
  );

  always #5 clock = ~clock;

  // Memory models
  function automatic logic [31:0] ld_ext(input logic [31:0] w, input logic [2:0] op,
                                         input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      MEM_B:   return {{24{b[7]}}, b};
      MEM_H:   return {{16{h[15]}}, h};
      MEM_BU:  return {24'd0, b};
      MEM_HU:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [2:0] op, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (op)
      MEM_B:   r[8*a +: 8] = d[7:0];
      MEM_H:   r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge imemclk) imemdataout <= rom[imemaddr[7:2]];

  always @(posedge dmemrdclk) dmemdataout = ld_ext(dmem[dmemaddr[9:2]], dmemop, dmemaddr[1:0]);

  always @(posedge dmemwrclk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 32'd0;
    end else if (dmemwe === 1'b1) begin
      dmem[dmemaddr[9:2]] <= st_merge(dmem[dmemaddr[9:2]], dmemdatain, dmemop, dmemaddr[1:0]);
    end
  end

  // Instruction encoders
  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [2:0] f3, input logic [31:0] rd,
                                        input logic [6:0] opc);
    return {imm[11:0], rs1[4:0], f3, rd[4:0], opc};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [2:0] f3,
                                        input logic [31:0] rd);
    return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], OPC_OP};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3, imm[4:0], OPC_STORE};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm, input logic [31:0] rd,
                                        input logic [6:0] opc);
    return {imm[19:0], rd[4:0], opc};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OPC_JAL};
  endfunction

  // Checking and scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_ret(input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.st = 1'b0; e.addr = 32'd0; e.data = 32'd0; e.op = 3'd0;
    q.push_back(e);
  endtask

  task automatic exp_st(input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] data, input logic [2:0] op);
    exp_t e;
    e.pc = pc; e.st = 1'b1; e.addr = addr; e.data = data; e.op = op;
    q.push_back(e);
  endtask

  task automatic score();
    exp_t e;
    check("wb", {31'd0, wb}, 32'd1);
    check("sb_nonempty", {31'd0, q.size() != 0}, 32'd1);
    if (wb === 1'b1 && q.size() != 0) begin
      e = q.pop_front();
      check("dbg_pc", dbg_pc, e.pc);
      check("dmemwe", {31'd0, dmemwe}, {31'd0, e.st});
      if (e.st) begin
        check("st_addr", dmemaddr, e.addr);
        check("st_data", dmemdatain, e.data);
        check("st_op", {29'd0, dmemop}, {29'd0, e.op});
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      score();
    end
  endtask

  task automatic run_until_halt(input int budget, input logic [31:0] halt_pc);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (done === 1'b1) break;
      if (cyc >= budget) begin
        n_checks++;
        n_fail++;
        $error("FAIL timeout: no halt after %0d cycles, dbg_pc %h expected halt at %h",
               budget, dbg_pc, halt_pc);
        break;
      end
      score();
      cyc++;
    end
    check("sb_drained", q.size(), 32'd0);
    for (int i = 0; i < 12; i++) begin
      check("halt_done", {31'd0, done}, 32'd1);
      check("halt_wb", {31'd0, wb}, 32'd0);
      check("halt_we", {31'd0, dmemwe}, 32'd0);
      check("halt_pc", dbg_pc, halt_pc);
      check("halt_imemaddr", imemaddr, halt_pc);
      @(negedge clock);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'd0;
  endtask

  // Programs; rom index = byte address / 4
  task automatic load_prog1();
    clear_rom();
    rom[0] = enc_i(5, 0, 3'b000, 1, OPC_OP_IMM);            // addi x1,x0,5
    rom[1] = enc_i(-7, 1, 3'b000, 2, OPC_OP_IMM);           // addi x2,x1,-7
    rom[2] = enc_r(7'h20, 2, 1, 3'b000, 3);                 // sub x3,x1,x2
    rom[3] = enc_s(32'h40, 3, 0, MEM_W);                    // sw x3,0x40(x0)
    rom[4] = enc_j(8, 1);                                   // jal x1,+8
    rom[5] = enc_i(10, 1, 3'b000, 1, OPC_OP_IMM);           // addi x1,x1,10
    rom[6] = enc_i(3, 1, 3'b000, 0, OPC_JALR);              // jalr x0,x1,3
  endtask

  task automatic push_prog1();
    exp_ret(32'h00); exp_ret(32'h04); exp_ret(32'h08);
    exp_st(32'h0C, 32'h40, 32'h7, MEM_W);
    exp_ret(32'h10); exp_ret(32'h18); exp_ret(32'h16); exp_ret(32'h1A);
  endtask

  task automatic load_prog2();
    clear_rom();
    rom[0]  = enc_u(32'h12345, 5, OPC_LUI);                 // lui x5,0x12345
    rom[1]  = enc_i(32'h678, 5, 3'b000, 5, OPC_OP_IMM);     // addi x5,x5,0x678
    rom[2]  = enc_s(0, 5, 0, MEM_W);                        // sw x5,0(x0)
    rom[3]  = enc_i(1, 0, MEM_B, 6, OPC_LOAD);              // lb x6,1(x0)
    rom[4]  = enc_i(2, 0, MEM_HU, 7, OPC_LOAD);             // lhu x7,2(x0)
    rom[5]  = enc_s(32'h40, 6, 0, MEM_W);                   // sw x6,0x40(x0)
    rom[6]  = enc_s(32'h44, 7, 0, MEM_W);                   // sw x7,0x44(x0)
    rom[7]  = enc_i(-128, 0, 3'b000, 9, OPC_OP_IMM);        // addi x9,x0,-128
    rom[8]  = enc_s(32'h4B, 9, 0, MEM_B);                   // sb x9,0x4B(x0)
    rom[9]  = enc_i(32'h4B, 0, MEM_B, 10, OPC_LOAD);        // lb x10,0x4B(x0)
    rom[10] = enc_i(32'h4B, 0, MEM_BU, 11, OPC_LOAD);       // lbu x11,0x4B(x0)
    rom[11] = enc_i(32'h48, 0, MEM_W, 12, OPC_LOAD);        // lw x12,0x48(x0)
    rom[12] = enc_s(32'h4C, 10, 0, MEM_W);                  // sw x10,0x4C(x0)
    rom[13] = enc_s(32'h50, 11, 0, MEM_W);                  // sw x11,0x50(x0)
    rom[14] = enc_s(32'h54, 12, 0, MEM_W);                  // sw x12,0x54(x0)
    rom[15] = enc_i(32'h4A, 0, MEM_H, 13, OPC_LOAD);        // lh x13,0x4A(x0)
    rom[16] = enc_s(32'h58, 13, 0, MEM_W);                  // sw x13,0x58(x0)
  endtask

  task automatic push_prog2();
    exp_ret(32'h00); exp_ret(32'h04);
    exp_st(32'h08, 32'h00, 32'h1234_5678, MEM_W);
    exp_ret(32'h0C); exp_ret(32'h10);
    exp_st(32'h14, 32'h40, 32'h0000_0056, MEM_W);
    exp_st(32'h18, 32'h44, 32'h0000_1234, MEM_W);
    exp_ret(32'h1C);
    exp_st(32'h20, 32'h4B, 32'hFFFF_FF80, MEM_B);
    exp_ret(32'h24); exp_ret(32'h28); exp_ret(32'h2C);
    exp_st(32'h30, 32'h4C, 32'hFFFF_FF80, MEM_W);
    exp_st(32'h34, 32'h50, 32'h0000_0080, MEM_W);
    exp_st(32'h38, 32'h54, 32'h8000_0000, MEM_W);
    exp_ret(32'h3C);
    exp_st(32'h40, 32'h58, 32'hFFFF_8000, MEM_W);
  endtask

  task automatic load_prog3();
    clear_rom();
    rom[0]  = enc_i(-1, 0, 3'b000, 1, OPC_OP_IMM);          // addi x1,x0,-1
    rom[1]  = enc_i(1, 0, 3'b000, 2, OPC_OP_IMM);           // addi x2,x0,1
    rom[2]  = enc_b(8, 2, 1, BR_BLT);                       // blt x1,x2,+8
    rom[3]  = enc_i(99, 0, 3'b000, 3, OPC_OP_IMM);          // addi x3,x0,99 (skipped)
    rom[4]  = enc_b(8, 2, 1, BR_BLTU);                      // bltu x1,x2,+8
    rom[5]  = enc_r(7'h20, 2, 1, 3'b101, 4);                // sra x4,x1,x2
    rom[6]  = enc_r(7'h00, 2, 1, 3'b101, 5);                // srl x5,x1,x2
    rom[7]  = enc_s(32'h40, 4, 0, MEM_W);                   // sw x4,0x40(x0)
    rom[8]  = enc_s(32'h44, 5, 0, MEM_W);                   // sw x5,0x44(x0)
    rom[9]  = enc_r(7'h00, 2, 1, 3'b010, 6);                // slt x6,x1,x2
    rom[10] = enc_r(7'h00, 2, 1, 3'b011, 7);                // sltu x7,x1,x2
    rom[11] = enc_r(7'h00, 2, 1, 3'b100, 8);                // xor x8,x1,x2
    rom[12] = enc_s(32'h48, 6, 0, MEM_W);                   // sw x6,0x48(x0)
    rom[13] = enc_s(32'h4C, 7, 0, MEM_W);                   // sw x7,0x4C(x0)
    rom[14] = enc_s(32'h50, 8, 0, MEM_W);                   // sw x8,0x50(x0)
    rom[15] = enc_i(31, 2, 3'b001, 10, OPC_OP_IMM);         // slli x10,x2,31
    rom[16] = enc_s(32'h54, 10, 0, MEM_W);                  // sw x10,0x54(x0)
    rom[17] = enc_b(8, 2, 1, BR_BGE);                       // bge x1,x2,+8
    rom[18] = enc_b(8, 2, 1, BR_BGEU);                      // bgeu x1,x2,+8
    rom[19] = enc_i(77, 0, 3'b000, 3, OPC_OP_IMM);          // addi x3,x0,77 (skipped)
    rom[20] = enc_u(1, 11, OPC_AUIPC);                      // auipc x11,1
    rom[21] = enc_s(32'h58, 11, 0, MEM_W);                  // sw x11,0x58(x0)
    rom[22] = enc_b(8, 0, 3, BR_BNE);                       // bne x3,x0,+8
    rom[23] = enc_s(32'h5C, 3, 0, MEM_W);                   // sw x3,0x5C(x0)
  endtask

  task automatic push_prog3();
    exp_ret(32'h00); exp_ret(32'h04); exp_ret(32'h08); exp_ret(32'h10);
    exp_ret(32'h14); exp_ret(32'h18);
    exp_st(32'h1C, 32'h40, 32'hFFFF_FFFF, MEM_W);
    exp_st(32'h20, 32'h44, 32'h7FFF_FFFF, MEM_W);
    exp_ret(32'h24); exp_ret(32'h28); exp_ret(32'h2C);
    exp_st(32'h30, 32'h48, 32'h0000_0001, MEM_W);
    exp_st(32'h34, 32'h4C, 32'h0000_0000, MEM_W);
    exp_st(32'h38, 32'h50, 32'hFFFF_FFFE, MEM_W);
    exp_ret(32'h3C);
    exp_st(32'h40, 32'h54, 32'h8000_0000, MEM_W);
    exp_ret(32'h44); exp_ret(32'h48); exp_ret(32'h50);
    exp_st(32'h54, 32'h58, 32'h0000_1050, MEM_W);
    exp_ret(32'h58);
    exp_st(32'h5C, 32'h5C, 32'h0000_0000, MEM_W);
  endtask

  // Holds reset over two rising edges so the ROM latches word 0, then releases just after an edge.
  task automatic release_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, dbg_pc, 32'h0);
    check({tag, "_imemaddr"}, imemaddr, 32'h0);
    check({tag, "_wb"}, {31'd0, wb}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_we"}, {31'd0, dmemwe}, 32'd0);
`ifdef RV32IS_DBG_REGS_EN
    for (int i = 0; i < 32; i++) check({tag, "_reg"}, dbgregs[32*i +: 32], 32'd0);
`endif
  endtask

  initial begin
    // Arithmetic, jal/jalr with odd target, halt
    reset = 1'b0;
    load_prog1();
    push_prog1();
    repeat (2) @(posedge clock);
    #1 check_reset_state("por");
    reset = 1'b1;
    run_until_halt(100, 32'h20);

    // Reset while halted clears the sticky halt
    reset = 1'b0;
    #1 check_reset_state("halt_rst");

    // Reset mid-program, then the identical trace again
    load_prog1();
    push_prog1();
    release_reset();
    run_cycles(5);
    #2 reset = 1'b0;
    #1 check_reset_state("mid_rst");
    q.delete();
    load_prog1();
    push_prog1();
    release_reset();
    run_until_halt(100, 32'h20);

    // Stores, sign/zero-extending loads, byte lanes
    reset = 1'b0;
    load_prog2();
    push_prog2();
    release_reset();
    run_until_halt(100, 32'h44);

    // Branches and remaining ALU operations
    reset = 1'b0;
    load_prog3();
    push_prog3();
    release_reset();
    run_until_halt(100, 32'h60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
